time_alarm_editor: RTL and testbench
====================================

# time_alarm_editor

Multi-channel, parametrised time/alarm adjustment controller. It sits between the debounced push-buttons and the timekeeping and alarm registers. It lets the user select any field of the clock time or one of NUM_ALARMS alarms and edit it in shadow registers with hold-to-repeat. The edits are released to the owners of those registers by a single-cycle commit strobe with a per-channel change mask.

## Interface
- NUM_ALARMS, 2: alarm channels. Channel 0 is the clock time; channels 1..NUM_ALARMS are alarms.
- HOUR_MODULO, 24: hour wrap value (12 or 24).
- REPEAT_DELAY, 50: hold cycles before auto-repeat starts.
- REPEAT_PERIOD, 10: cycles between auto-repeat steps.
- IDLE_TIMEOUT, 1000: cycles without a button edge before edit is abandoned. 0 disables the timeout.
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-low reset.
- buttons  in  5  debounced levels: [0] enter/exit, [1] left, [2] right, [3] up, [4] down.
- in_hours  in  5*(NUM_ALARMS+1)  current hours per channel, flattened, channel 0 in LSBs.
- in_minutes  in  6*(NUM_ALARMS+1)  current minutes per channel, flattened.
- out_hours  out  5*(NUM_ALARMS+1)  shadow hours.
- out_minutes  out  6*(NUM_ALARMS+1)  shadow minutes.
- commit  out  1  one-cycle strobe at the end of an edit session.
- commit_mask  out  NUM_ALARMS+1  channels whose shadow differs from the snapshot.
- editing  out  1  high while in EDIT.
- field_sel  out  clog2(2*(NUM_ALARMS+1))  cursor. Even values are hours, odd values are minutes; channel = field_sel/2.
- sel_units / sel_tens  out  4 / 3  decimal digits of the selected shadow field.
- led  out  2*(NUM_ALARMS+1)  one-hot cursor while editing; 0 otherwise.

## Operation
- Button edges: the previous level of each button is registered; rising = level & ~previous. Only rising edges act, except for auto-repeat.
- Reset values: state IDLE, field_sel 0, all shadows 0, commit 0, commit_mask 0, editing 0, led 0, repeat and timeout counters 0.
- IDLE:
  - The shadows load from in_hours/in_minutes every cycle.
  - A rising edge on enter goes to EDIT and freezes the snapshot of all inputs. field_sel is set to 0.
- EDIT:
  - Left/right rising edges move the cursor by -1/+1 and wrap at both ends. Left and right together cause no move.
  - An up/down rising edge adds or subtracts 1 on the selected shadow field.
    - Minutes wrap 59↔0.
    - Hours wrap HOUR_MODULO-1↔0.
  - Up and down together cause no change and clear the repeat counter.
  - A rising edge on enter goes to COMMIT. Any up/down/left/right in the same cycle is ignored.
  - Timeout: IDLE_TIMEOUT consecutive cycles with no rising edge return to IDLE without commit. Shadows then reload from the inputs.
- COMMIT (1 cycle):
  - commit=1.
  - commit_mask[c] = 1 iff channel c's shadow hours or minutes differ from the snapshot.
  - Next state is IDLE.
  - Shadows hold their edited values during COMMIT.
  - An all-zero mask still pulses commit.
- Out-of-range inputs (minutes>59, hours≥HOUR_MODULO) are captured unchanged. The first up/down step sets the field to 0.
- Reset mid-edit discards all edits; no commit is issued.

## Timing
- A button level first sampled high at edge k takes effect on edge k: the shadow, cursor and state outputs change after edge k.
- In IDLE, outputs follow the inputs with 1-cycle latency.
- commit_mask and the final shadows are valid in the same cycle as commit.
- Auto-repeat: while up (or down) stays high, steps occur at the edge edge, then edge+REPEAT_DELAY, then every REPEAT_PERIOD cycles.
- The repeat counter clears on release and on a cursor move.

## Configuration
- AUTO_REPEAT_EN defined: hold-to-repeat is built as described in Operation and Timing.
- AUTO_REPEAT_EN undefined: only rising edges step the field. The repeat counter and the REPEAT_* parameters are unused. Holding up gives exactly one step.

## Structure
- Package time_alarm_pkg holds:
  - the state enum IDLE/EDIT/COMMIT;
  - MIN_MODULO=60 and the button index constants;
  - the width function for field_sel.
- One sub-module, field_step_counter: a parametrised modulo-N up/down step with wrap and out-of-range clamp. It is instantiated per shadow field or shared through a mux.

## Test plan
- Reset low mid-EDIT with modified shadows → state IDLE, commit never pulses, shadows equal the inputs one cycle after rst goes high.
- Enter, right ×1, up ×3 on channel 0 minutes 58 → shadow minutes 58→59→0→1. Enter → commit=1 for one cycle, commit_mask=3'b001.
- Cursor at field 0, left → field_sel = 2*NUM_ALARMS+1 (5 for defaults), led=6'b100000. Left+right together → no move.
- Up held 100 cycles with AUTO_REPEAT_EN, defaults, alarm1 hours 22 → steps at cycles 0, 50, 60, 70, 80, 90. Final value (22+6) mod 24 = 4.
- Enter, then no buttons for IDLE_TIMEOUT cycles → editing falls, no commit, shadows reload from the inputs.
- Enter and up rising in the same cycle while in EDIT → COMMIT. Shadow unchanged; commit_mask is 0 if nothing was edited, and commit still pulses.

Source files
------------

// File: rtl/time_alarm_editor_pkg.sv
// Shared constants for the time/alarm editor: FSM encoding, button indices, field widths.
// Pure declarations; no logic, no latency.
package time_alarm_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_EDIT   = 2'd1;
   localparam state_t ST_COMMIT = 2'd2;

   localparam int MIN_MODULO = 60;

   localparam int BTN_ENTER = 0;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_RIGHT = 2;
   localparam int BTN_UP    = 3;
   localparam int BTN_DOWN  = 4;

   function automatic int sel_width(input int num_alarms);
      return $clog2(2 * (num_alarms + 1));
   endfunction

endpackage

// File: rtl/time_alarm_editor_if.sv
// Button/register-side bundle of the time/alarm editor; slave = editor, master = surroundings.
// Wires only; buttons are levels, so there is no backpressure.
interface time_alarm_editor_if #(
   parameter int NUM_ALARMS = 2
) ();
   localparam int NUM_CH = NUM_ALARMS + 1;
   localparam int SEL_W  = time_alarm_pkg::sel_width(NUM_ALARMS);

   logic [4:0]          buttons;
   logic [5*NUM_CH-1:0] in_hours;
   logic [6*NUM_CH-1:0] in_minutes;
   logic [5*NUM_CH-1:0] out_hours;
   logic [6*NUM_CH-1:0] out_minutes;
   logic                commit;
   logic [NUM_CH-1:0]   commit_mask;
   logic                editing;
   logic [SEL_W-1:0]    field_sel;
   logic [3:0]          sel_units;
   logic [2:0]          sel_tens;
   logic [2*NUM_CH-1:0] led;

   modport slave (
      input  buttons, in_hours, in_minutes,
      output out_hours, out_minutes, commit, commit_mask, editing,
             field_sel, sel_units, sel_tens, led
   );

   modport master (
      output buttons, in_hours, in_minutes,
      input  out_hours, out_minutes, commit, commit_mask, editing,
             field_sel, sel_units, sel_tens, led
   );
endinterface

// File: rtl/time_alarm_editor_field_step_counter.sv
// Modulo-MODULO +/-1 step with wrap; an out-of-range value snaps to 0 on any step.
// Combinational, zero latency; up and down together leave the value unchanged.
module field_step_counter #(
   parameter int MODULO = 60,
   parameter int WIDTH  = 6
) (
   input  logic [WIDTH-1:0] value,
   input  logic             up,
   input  logic             down,
   output logic [WIDTH-1:0] next
);
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 1);

   always_comb begin
      next = value;
      if (up != down) begin
         if (value > MAXV)
            next = '0;
         else if (up)
            next = (value == MAXV) ? '0 : value + WIDTH'(1);
         else
            next = (value == '0) ? MAXV : value - WIDTH'(1);
      end
   end
endmodule

// File: rtl/time_alarm_editor.sv
// Time/alarm field editor with shadow registers and a one-cycle commit strobe + change mask.
// Buttons act on the edge that first samples them high; AUTO_REPEAT_EN adds hold-to-repeat.
module time_alarm_editor
   import time_alarm_pkg::*;
#(
   parameter int NUM_ALARMS    = 2,
   parameter int HOUR_MODULO   = 24,
   parameter int REPEAT_DELAY  = 50,
   parameter int REPEAT_PERIOD = 10,
   parameter int IDLE_TIMEOUT  = 1000
) (
   input  logic           clk,
   input  logic           rst,
   time_alarm_editor_if.slave bus
);
   localparam int NUM_CH     = NUM_ALARMS + 1;
   localparam int NUM_FIELDS = 2 * NUM_CH;
   localparam int SEL_W      = sel_width(NUM_ALARMS);
   localparam int TO_W       = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam logic [SEL_W-1:0] LAST_FIELD = SEL_W'(NUM_FIELDS - 1);
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(IDLE_TIMEOUT - 1);

   state_t           state;
   logic [4:0]       btn_prev, rise;
   logic [SEL_W-1:0] field_sel, sel_ch;
   logic [TO_W-1:0]  to_cnt;
   logic [4:0]       sh_hours [NUM_CH];
   logic [5:0]       sh_mins  [NUM_CH];
   logic [4:0]       snap_hours [NUM_CH];
   logic [5:0]       snap_mins  [NUM_CH];
   logic             enter_rise, edit_act, move_l, move_r, step_up, step_dn, timeout;
   logic [4:0]       sel_hr, next_hr;
   logic [5:0]       sel_mn, next_mn, sel_val;
   logic [5*NUM_CH-1:0] hours_flat;
   logic [6*NUM_CH-1:0] mins_flat;
   logic [NUM_CH-1:0]   mask;

   assign rise       = bus.buttons & ~btn_prev;
   assign enter_rise = rise[BTN_ENTER];
   // enter wins over every other button in the same cycle
   assign edit_act   = (state == ST_EDIT) && !enter_rise;
   assign move_l     = edit_act && rise[BTN_LEFT] && !rise[BTN_RIGHT];
   assign move_r     = edit_act && rise[BTN_RIGHT] && !rise[BTN_LEFT];
   assign timeout    = (IDLE_TIMEOUT != 0) && (state == ST_EDIT) && (rise == '0) && (to_cnt == TO_LAST);

`ifdef AUTO_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
   localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY);
   localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic             rpt_clr, rpt_fire;

   // rpt_cnt holds edges since the press (0 = not armed); firing rewinds it by one period
   assign rpt_clr  = !edit_act || (bus.buttons[BTN_UP] == bus.buttons[BTN_DOWN]) || move_l || move_r;
   assign rpt_fire = !rpt_clr && (rpt_cnt == RPT_FIRE);
   assign step_up  = edit_act && (rise[BTN_UP] || (rpt_fire && bus.buttons[BTN_UP]));
   assign step_dn  = edit_act && (rise[BTN_DOWN] || (rpt_fire && bus.buttons[BTN_DOWN]));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                rpt_cnt <= '0;
      else if (rpt_clr)                        rpt_cnt <= '0;
      else if (rise[BTN_UP] || rise[BTN_DOWN]) rpt_cnt <= RPT_W'(1);
      else if (rpt_fire)                       rpt_cnt <= RPT_RELOAD;
      else if (rpt_cnt != '0)                  rpt_cnt <= rpt_cnt + RPT_W'(1);
   end
`else
   logic unused_rpt;
   assign unused_rpt = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
   assign step_up    = edit_act && rise[BTN_UP];
   assign step_dn    = edit_act && rise[BTN_DOWN];
`endif

   assign sel_ch = field_sel >> 1;

   always_comb begin
      sel_hr = '0;
      sel_mn = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (SEL_W'(c) == sel_ch) begin
            sel_hr = sh_hours[c];
            sel_mn = sh_mins[c];
         end
      end
   end

   field_step_counter #(.MODULO(HOUR_MODULO), .WIDTH(5)) u_hour_step (
      .value(sel_hr), .up(step_up), .down(step_dn), .next(next_hr)
   );
   field_step_counter #(.MODULO(MIN_MODULO), .WIDTH(6)) u_min_step (
      .value(sel_mn), .up(step_up), .down(step_dn), .next(next_mn)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         field_sel <= '0;
         btn_prev  <= '0;
         to_cnt    <= '0;
      end else begin
         btn_prev <= bus.buttons;
         to_cnt   <= (state != ST_EDIT || rise != '0) ? '0 : to_cnt + TO_W'(1);
         case (state)
            ST_IDLE: if (enter_rise) begin
               state     <= ST_EDIT;
               field_sel <= '0;
            end
            ST_EDIT: begin
               if (enter_rise)  state     <= ST_COMMIT;
               else if (timeout) state    <= ST_IDLE;
               if (move_r)      field_sel <= (field_sel == LAST_FIELD) ? '0 : field_sel + SEL_W'(1);
               else if (move_l) field_sel <= (field_sel == '0) ? LAST_FIELD : field_sel - SEL_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            sh_hours[c]   <= '0;
            sh_mins[c]    <= '0;
            snap_hours[c] <= '0;
            snap_mins[c]  <= '0;
         end
      end else if (state == ST_IDLE) begin
         for (int c = 0; c < NUM_CH; c++) begin
            sh_hours[c] <= bus.in_hours[5*c +: 5];
            sh_mins[c]  <= bus.in_minutes[6*c +: 6];
            if (enter_rise) begin
               snap_hours[c] <= bus.in_hours[5*c +: 5];
               snap_mins[c]  <= bus.in_minutes[6*c +: 6];
            end
         end
      end else if (step_up || step_dn) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (SEL_W'(c) == sel_ch) begin
               if (field_sel[0]) sh_mins[c]  <= next_mn;
               else              sh_hours[c] <= next_hr;
            end
         end
      end
   end

   always_comb begin
      hours_flat = '0;
      mins_flat  = '0;
      mask       = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         hours_flat[5*c +: 5] = sh_hours[c];
         mins_flat[6*c +: 6]  = sh_mins[c];
         mask[c] = (state == ST_COMMIT) &&
                   ((sh_hours[c] != snap_hours[c]) || (sh_mins[c] != snap_mins[c]));
      end
   end

   assign sel_val         = field_sel[0] ? sel_mn : {1'b0, sel_hr};
   assign bus.out_hours   = hours_flat;
   assign bus.out_minutes = mins_flat;
   assign bus.commit      = (state == ST_COMMIT);
   assign bus.commit_mask = mask;
   assign bus.editing     = (state == ST_EDIT);
   assign bus.field_sel   = field_sel;
   assign bus.led         = (state == ST_EDIT) ? (NUM_FIELDS'(1) << field_sel) : '0;
   assign bus.sel_tens    = 3'(sel_val / 6'd10);
   assign bus.sel_units   = 4'(sel_val % 6'd10);
endmodule

// File: tb/tb_time_alarm_editor.sv
// Bench for time_alarm_editor: directed scenarios plus random button traffic against a reference model.
module tb_time_alarm_editor;
   import time_alarm_pkg::*;

   localparam int NA = 2, HM = 24, RD = 50, RP = 10, IT = 1000;
   localparam int NCH = NA + 1;
   localparam int NF  = 2 * NCH;
`ifdef AUTO_REPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   localparam logic [4:0] B_ENT = 5'(1 << BTN_ENTER);
   localparam logic [4:0] B_L   = 5'(1 << BTN_LEFT);
   localparam logic [4:0] B_R   = 5'(1 << BTN_RIGHT);
   localparam logic [4:0] B_UP  = 5'(1 << BTN_UP);
   localparam logic [4:0] B_DN  = 5'(1 << BTN_DOWN);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   time_alarm_editor_if #(.NUM_ALARMS(NA)) bus ();

   time_alarm_editor #(
      .NUM_ALARMS(NA), .HOUR_MODULO(HM), .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP), .IDLE_TIMEOUT(IT)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model: mode 0 idle, 1 edit, 2 commit
   int m_mode, m_sel, m_held, m_quiet;
   int m_h[NCH], m_m[NCH], m_sh[NCH], m_sm[NCH];
   int d_h[NCH], d_m[NCH];
   logic [4:0] m_prev;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int bump(input int v, input int modu, input int dir);
      if (v >= modu) return 0;
      return (v + dir + modu) % modu;
   endfunction

   function automatic logic [5*NCH-1:0] pack_h();
      logic [5*NCH-1:0] r;
      for (int c = 0; c < NCH; c++) r[5*c +: 5] = 5'(d_h[c]);
      return r;
   endfunction

   function automatic logic [6*NCH-1:0] pack_m();
      logic [6*NCH-1:0] r;
      for (int c = 0; c < NCH; c++) r[6*c +: 6] = 6'(d_m[c]);
      return r;
   endfunction

   task automatic apply_inputs();
      bus.in_hours   = pack_h();
      bus.in_minutes = pack_m();
   endtask

   task automatic randomize_inputs();
      for (int c = 0; c < NCH; c++) begin
         d_h[c] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23));
         d_m[c] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 63)) : int'($urandom_range(0, 59));
      end
      apply_inputs();
   endtask

   function automatic void model_reset();
      m_mode = 0; m_sel = 0; m_held = -1; m_quiet = 0; m_prev = '0;
      for (int c = 0; c < NCH; c++) begin
         m_h[c] = 0; m_m[c] = 0; m_sh[c] = 0; m_sm[c] = 0;
      end
   endfunction

   function automatic void model_step(input logic [4:0] b);
      logic [4:0] r;
      int dir, mv, ch;
      r = b & ~m_prev;
      m_prev = b;
      case (m_mode)
         0: begin
            for (int c = 0; c < NCH; c++) begin
               m_h[c] = d_h[c]; m_m[c] = d_m[c];
            end
            if (r[BTN_ENTER]) begin
               m_mode = 1; m_sel = 0; m_quiet = 0; m_held = -1;
               for (int c = 0; c < NCH; c++) begin
                  m_sh[c] = d_h[c]; m_sm[c] = d_m[c];
               end
            end
         end
         1: begin
            if (r[BTN_ENTER]) begin
               m_mode = 2; m_held = -1;
            end else begin
               dir = int'(r[BTN_UP]) - int'(r[BTN_DOWN]);
               mv  = int'(r[BTN_RIGHT]) - int'(r[BTN_LEFT]);
               if (AR) begin
                  if ((b[BTN_UP] == b[BTN_DOWN]) || mv != 0) m_held = -1;
                  else if (r[BTN_UP] || r[BTN_DOWN]) m_held = 0;
                  else if (m_held >= 0) begin
                     m_held++;
                     if (m_held >= RD && (m_held - RD) % RP == 0) dir = b[BTN_UP] ? 1 : -1;
                  end
               end
               ch = m_sel / 2;
               if (dir != 0) begin
                  if (m_sel % 2 == 1) m_m[ch] = bump(m_m[ch], 60, dir);
                  else                m_h[ch] = bump(m_h[ch], HM, dir);
               end
               if (mv != 0) m_sel = (m_sel + mv + NF) % NF;
               if (r != '0) m_quiet = 0;
               else         m_quiet++;
               if (IT != 0 && m_quiet >= IT) m_mode = 0;
            end
         end
         default: m_mode = 0;
      endcase
   endfunction

   task automatic compare_all();
      logic [5*NCH-1:0] eh;
      logic [6*NCH-1:0] em;
      logic [NCH-1:0]   emask;
      int v;
      for (int c = 0; c < NCH; c++) begin
         eh[5*c +: 5] = 5'(m_h[c]);
         em[6*c +: 6] = 6'(m_m[c]);
         emask[c] = (m_mode == 2) && (m_h[c] != m_sh[c] || m_m[c] != m_sm[c]);
      end
      v = (m_sel % 2 == 1) ? m_m[m_sel / 2] : m_h[m_sel / 2];
      check("editing", bus.editing, m_mode == 1);
      check("commit", bus.commit, m_mode == 2);
      check("commit_mask", bus.commit_mask, emask);
      check("field_sel", bus.field_sel, m_sel);
      check("led", bus.led, (m_mode == 1) ? (64'd1 << m_sel) : 64'd0);
      check("sel_units", bus.sel_units, v % 10);
      check("sel_tens", bus.sel_tens, v / 10);
      check("out_hours", bus.out_hours, eh);
      check("out_minutes", bus.out_minutes, em);
   endtask

   task automatic tick(input logic [4:0] b);
      @(negedge clk);
      bus.buttons = b;
      @(posedge clk);
      model_step(b);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      bus.buttons = '0;
      rst = 1'b0;
      model_reset();
      #1;
      compare_all();
      check("rst_editing", bus.editing, 0);
      check("rst_commit", bus.commit, 0);
      check("rst_hours", bus.out_hours, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      model_step('0);
      #1;
      compare_all();
   endtask

   initial begin
      int exp_min[3];
      logic [4:0] btn;
      int k;
      exp_min = '{59, 0, 1};
      rst = 1'b1;
      bus.buttons = '0;
      for (int c = 0; c < NCH; c++) begin
         d_h[c] = 10 + c; d_m[c] = 20 + c;
      end
      apply_inputs();
      #1;
      do_reset();

      // reset while editing discards the edit and reloads from the inputs
      tick(B_ENT); tick('0); tick(B_UP); tick('0);
      check("edit_hour", bus.out_hours[4:0], 11);
      do_reset();
      check("reload_hours", bus.out_hours, pack_h());
      check("reload_minutes", bus.out_minutes, pack_m());

      // minute wrap on channel 0 and commit mask
      d_m[0] = 58; apply_inputs(); tick('0);
      tick(B_ENT); tick('0); tick(B_R); tick('0);
      check("cursor_min0", bus.field_sel, 1);
      for (int i = 0; i < 3; i++) begin
         tick(B_UP);
         check("min_step", bus.out_minutes[5:0], exp_min[i]);
         tick('0);
      end
      tick(B_ENT);
      check("commit_pulse", bus.commit, 1);
      check("commit_mask_ch0", bus.commit_mask, 3'b001);
      tick('0);
      check("commit_single", bus.commit, 0);

      // cursor wrap left and simultaneous left+right
      tick(B_ENT); tick('0); tick(B_L);
      check("wrap_left", bus.field_sel, 5);
      check("wrap_led", bus.led, 6'b100000);
      tick('0); tick(B_L | B_R);
      check("lr_nomove", bus.field_sel, 5);
      tick('0); tick(B_ENT); tick('0);

      // hold up on alarm1 hours
      d_h[1] = 22; apply_inputs(); tick('0);
      tick(B_ENT); tick('0); tick(B_R); tick('0); tick(B_R); tick('0);
      check("cursor_alarm1", bus.field_sel, 2);
      for (int i = 0; i < 100; i++) tick(B_UP);
      check("repeat_hours", bus.out_hours[9:5], AR ? 4 : 23);
      tick('0); tick(B_ENT);
      check("commit_mask_ch1", bus.commit_mask, 3'b010);
      tick('0);

      // idle timeout abandons the edit
      tick(B_ENT); tick('0); tick(B_DN);
      for (int i = 0; i < IT - 1; i++) tick('0);
      check("pre_timeout", bus.editing, 1);
      tick('0);
      check("timeout_exit", bus.editing, 0);
      check("timeout_nocommit", bus.commit, 0);
      tick('0);
      check("timeout_reload", bus.out_hours, pack_h());

      // enter and up in the same cycle
      tick(B_ENT); tick('0); tick(B_ENT | B_UP);
      check("enter_up_commit", bus.commit, 1);
      check("enter_up_mask", bus.commit_mask, 0);
      check("enter_up_hours", bus.out_hours, pack_h());
      tick('0);

      btn = '0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            k = int'($urandom_range(0, 4));
            btn[k] = ~btn[k];
         end
         if ($urandom_range(0, 199) == 0) randomize_inputs();
         if ($urandom_range(0, 999) == 0) begin
            do_reset();
            btn = '0;
         end else begin
            tick(btn);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
